// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the traffic light and its passive monitor:
//   - phase encoding (NS green, NS yellow, EW green, EW yellow)
//   - monitor error codes (first error is latched, 0 = none)
//   - monitor FSM states
//   - 6-bit lamp patterns, ordered {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r}
// No ports (package).
// -----------------------------------------------------------------------------
package traffic_pkg;

  typedef enum logic [1:0] {
    PH_NS_G = 2'd0,
    PH_NS_Y = 2'd1,
    PH_EW_G = 2'd2,
    PH_EW_Y = 2'd3
  } phase_e;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_ILLEGAL = 3'd1,
    ERR_BAD_SEQ = 3'd2,
    ERR_BAD_DUR = 3'd3,
    ERR_UNSYNC  = 3'd4
  } err_code_e;

  typedef enum logic {
    ST_SYNC  = 1'b0,
    ST_TRACK = 1'b1
  } mon_state_e;

  localparam logic [5:0] LAMPS_NS_G = 6'b100001;
  localparam logic [5:0] LAMPS_NS_Y = 6'b010001;
  localparam logic [5:0] LAMPS_EW_G = 6'b001100;
  localparam logic [5:0] LAMPS_EW_Y = 6'b001010;

endpackage

// File: rtl/traffic_light_monitor_lamp_decode.sv
// -----------------------------------------------------------------------------
// lamp_decode
// Combinational decode of the six lamp outputs into a traffic phase.
// Ports:
//   lamps [5:0] in  : {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r}
//   valid       out : lamps match one of the four legal patterns
//   phase [1:0] out : decoded phase (PH_NS_G when not valid)
// -----------------------------------------------------------------------------
module lamp_decode
  import traffic_pkg::*;
(
  input  logic [5:0] lamps,
  output logic       valid,
  output logic [1:0] phase
);

  // Match the lamp vector against the four legal patterns.
  always_comb begin
    valid = 1'b1;
    phase = PH_NS_G;
    case (lamps)
      LAMPS_NS_G: phase = PH_NS_G;
      LAMPS_NS_Y: phase = PH_NS_Y;
      LAMPS_EW_G: phase = PH_EW_G;
      LAMPS_EW_Y: phase = PH_EW_Y;
      default: begin
        valid = 1'b0;
        phase = PH_NS_G;
      end
    endcase
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// -----------------------------------------------------------------------------
// traffic_light_monitor
// Passive protocol checker for traffic_light. Decodes the lamps into a phase,
// follows NS_G -> NS_Y -> EW_G -> EW_Y, checks each phase lasts its configured
// number of ticks, latches the first error code and counts full light cycles.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   tick              : one-cycle pulse shared with the light
//   ns_g..ew_r        : observed lamp outputs
//   phase [1:0]       : tracked phase
//   synced            : a legal phase has been adopted
//   err               : sticky error flag
//   err_code [2:0]    : code of the first error (0 = none)
//   cycles [7:0]      : completed EW_Y -> NS_G wraps, saturating at 255
// -----------------------------------------------------------------------------
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int unsigned NS_G_TICKS = 5,
  parameter int unsigned NS_Y_TICKS = 2,
  parameter int unsigned EW_G_TICKS = 5,
  parameter int unsigned EW_Y_TICKS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       ns_g,
  input  logic       ns_y,
  input  logic       ns_r,
  input  logic       ew_g,
  input  logic       ew_y,
  input  logic       ew_r,
  output logic [1:0] phase,
  output logic       synced,
  output logic       err,
  output logic [2:0] err_code,
  output logic [7:0] cycles
);

  mon_state_e state_r, state_nx_s;
  logic [1:0] phase_r, phase_nx_s;
  logic [3:0] tcnt_r, tcnt_nx_s;
  logic       first_r, first_nx_s;
  logic       synced_r, synced_nx_s;
  logic [7:0] cycles_r, cycles_nx_s;
  logic       tick_d_r;
  logic       err_r;
  logic [2:0] err_code_r;

  logic       dec_valid_s;
  logic [1:0] dec_phase_s;
  logic       change_s;
  logic [3:0] dur_s;
  err_code_e  code_s;

  // Required tick count for a given phase.
  function automatic logic [3:0] dur_of(input logic [1:0] ph);
    logic [3:0] d;
    case (ph)
      PH_NS_G: d = 4'(NS_G_TICKS);
      PH_NS_Y: d = 4'(NS_Y_TICKS);
      PH_EW_G: d = 4'(EW_G_TICKS);
      PH_EW_Y: d = 4'(EW_Y_TICKS);
      default: d = 4'(NS_G_TICKS);
    endcase
    return d;
  endfunction

  lamp_decode u_lamp_decode (
    .lamps ({ns_g, ns_y, ns_r, ew_g, ew_y, ew_r}),
    .valid (dec_valid_s),
    .phase (dec_phase_s)
  );

  // Next-state, per-cycle protocol checks and tracking updates.
  always_comb begin
    state_nx_s  = state_r;
    phase_nx_s  = phase_r;
    tcnt_nx_s   = tcnt_r;
    first_nx_s  = first_r;
    synced_nx_s = synced_r;
    cycles_nx_s = cycles_r;
    change_s    = 1'b0;
    dur_s       = dur_of(phase_r);
    code_s      = ERR_NONE;
    case (state_r)
      ST_SYNC: begin
        if (dec_valid_s) begin
          state_nx_s  = ST_TRACK;
          phase_nx_s  = dec_phase_s;
          tcnt_nx_s   = 4'd0;
          first_nx_s  = 1'b1;
          synced_nx_s = 1'b1;
        end else begin
          state_nx_s = ST_SYNC;
        end
      end
      ST_TRACK: begin
        change_s = dec_valid_s && (dec_phase_s != phase_r);
        // Checks in priority order; the first phase after sync is of unknown
        // length, so duration checks are suppressed while first_r is set.
        if (!dec_valid_s) begin
          code_s = ERR_ILLEGAL;
        end else if (change_s && (dec_phase_s != (phase_r + 2'd1))) begin
          code_s = ERR_BAD_SEQ;
        end else if (change_s && !tick_d_r) begin
          code_s = ERR_UNSYNC;
        end else if (change_s && (tcnt_r != dur_s) && !first_r) begin
          code_s = ERR_BAD_DUR;
        end else if (!change_s && tick_d_r && (tcnt_r == dur_s) && !first_r) begin
          code_s = ERR_BAD_DUR;
        end else begin
          code_s = ERR_NONE;
        end
        // Any decodable change is adopted so tracking survives an error;
        // a tick in the same cycle counts toward the new phase.
        if (change_s) begin
          phase_nx_s = dec_phase_s;
          tcnt_nx_s  = {3'b000, tick};
          first_nx_s = 1'b0;
          if ((phase_r == PH_EW_Y) && (dec_phase_s == PH_NS_G) &&
              (code_s == ERR_NONE) && (cycles_r != 8'hFF)) begin
            cycles_nx_s = cycles_r + 8'd1;
          end else begin
            cycles_nx_s = cycles_r;
          end
        end else if (tick && (tcnt_r != 4'hF)) begin
          tcnt_nx_s = tcnt_r + 4'd1;
        end else begin
          tcnt_nx_s = tcnt_r;
        end
      end
      default: begin
        state_nx_s = ST_SYNC;
      end
    endcase
  end

  // State register, tick history and first-error capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_SYNC;
      phase_r    <= 2'd0;
      tcnt_r     <= 4'd0;
      first_r    <= 1'b0;
      synced_r   <= 1'b0;
      cycles_r   <= 8'd0;
      tick_d_r   <= 1'b0;
      err_r      <= 1'b0;
      err_code_r <= 3'd0;
    end else begin
      state_r  <= state_nx_s;
      phase_r  <= phase_nx_s;
      tcnt_r   <= tcnt_nx_s;
      first_r  <= first_nx_s;
      synced_r <= synced_nx_s;
      cycles_r <= cycles_nx_s;
      tick_d_r <= tick;
      if ((code_s != ERR_NONE) && !err_r) begin
        err_r      <= 1'b1;
        err_code_r <= code_s;
      end else begin
        err_r      <= err_r;
        err_code_r <= err_code_r;
      end
    end
  end

  assign phase    = phase_r;
  assign synced   = synced_r;
  assign err      = err_r;
  assign err_code = err_code_r;
  assign cycles   = cycles_r;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// -----------------------------------------------------------------------------
// tb_traffic_light_monitor
// Drives a behavioural light (randomised tick spacing) plus injected faults
// into two monitors: dut0 with 5/2/5/2 durations, dut1 with all durations 1.
// Expected outputs come from a phase/tick reference model kept here.
// -----------------------------------------------------------------------------
module tb_traffic_light_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic [5:0] lamps = 6'b000000;

  logic [1:0] phase0, phase1;
  logic       synced0, synced1, err0, err1;
  logic [2:0] err_code0, err_code1;
  logic [7:0] cycles0, cycles1;
  logic [14:0] out0, out1;

  int n_checks = 0;
  int n_errors = 0;

  logic [5:0] pat [4] = '{6'b100001, 6'b010001, 6'b001100, 6'b001010};

  // Reference model state
  int dur [4] = '{5, 2, 5, 2};
  bit m_synced = 1'b0;
  bit m_first = 1'b0;
  bit m_prev_tick = 1'b0;
  int m_phase = 0;
  int m_cnt = 0;
  int m_code = 0;
  int m_cycles = 0;

  traffic_light_monitor dut0 (
    .clk(clk), .rst(rst), .tick(tick),
    .ns_g(lamps[5]), .ns_y(lamps[4]), .ns_r(lamps[3]),
    .ew_g(lamps[2]), .ew_y(lamps[1]), .ew_r(lamps[0]),
    .phase(phase0), .synced(synced0), .err(err0),
    .err_code(err_code0), .cycles(cycles0)
  );

  traffic_light_monitor #(
    .NS_G_TICKS(1), .NS_Y_TICKS(1), .EW_G_TICKS(1), .EW_Y_TICKS(1)
  ) dut1 (
    .clk(clk), .rst(rst), .tick(tick),
    .ns_g(lamps[5]), .ns_y(lamps[4]), .ns_r(lamps[3]),
    .ew_g(lamps[2]), .ew_y(lamps[1]), .ew_r(lamps[0]),
    .phase(phase1), .synced(synced1), .err(err1),
    .err_code(err_code1), .cycles(cycles1)
  );

  assign out0 = {phase0, synced0, err0, err_code0, cycles0};
  assign out1 = {phase1, synced1, err1, err_code1, cycles1};

  always #5 clk = ~clk;

  function automatic int decode(input logic [5:0] l);
    for (int i = 0; i < 4; i++) begin
      if (l === pat[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [14:0] model_vec();
    logic [1:0] ph;
    logic [2:0] cd;
    logic [7:0] cy;
    ph = m_phase[1:0];
    cd = m_code[2:0];
    cy = m_cycles[7:0];
    return {ph, m_synced, (m_code != 0), cd, cy};
  endfunction

  // Apply the monitor rules for one sampled cycle.
  task automatic model_edge(input bit r, input bit t, input logic [5:0] l);
    int d;
    int code;
    bit chg;
    if (r) begin
      m_synced = 0; m_first = 0; m_prev_tick = 0;
      m_phase = 0; m_cnt = 0; m_code = 0; m_cycles = 0;
      return;
    end
    d = decode(l);
    code = 0;
    if (!m_synced) begin
      if (d >= 0) begin
        m_synced = 1; m_phase = d; m_cnt = 0; m_first = 1;
      end
    end else begin
      chg = (d >= 0) && (d != m_phase);
      if (d < 0) code = 1;
      else if (chg && d != (m_phase + 1) % 4) code = 2;
      else if (chg && !m_prev_tick) code = 4;
      else if (chg && m_cnt != dur[m_phase] && !m_first) code = 3;
      else if (!chg && m_prev_tick && m_cnt == dur[m_phase] && !m_first) code = 3;
      if (chg) begin
        if (code == 0 && m_phase == 3 && d == 0 && m_cycles < 255) m_cycles++;
        m_phase = d;
        m_cnt = t ? 1 : 0;
        m_first = 0;
      end else if (t && m_cnt < 15) begin
        m_cnt++;
      end
    end
    if (code != 0 && m_code == 0) m_code = code;
    m_prev_tick = t;
  endtask

  task automatic step(input bit r, input bit t, input logic [5:0] l);
    rst = r;
    tick = t;
    lamps = l;
    @(posedge clk);
    model_edge(r, t, l);
    #1;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, pat[0]);
    step(1'b1, 1'b0, pat[0]);
  endtask

  // Hold a phase's lamps for n ticks; each tick follows a random idle gap.
  task automatic run_phase(input int p, input int n, input int gmin, input int gmax);
    for (int k = 0; k < n; k++) begin
      int idle;
      idle = int'($urandom_range(gmax, gmin)) - 1;
      for (int i = 0; i < idle; i++) step(1'b0, 1'b0, pat[p]);
      step(1'b0, 1'b1, pat[p]);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      logic [5:0] rl;
      rl = 6'($urandom);
      step(1'b1, 1'($urandom), rl);
      n_checks++;
      if (out0 !== 15'd0) begin
        n_errors++;
        $display("FAIL reset_dut0: got %h expected %h", out0, 15'd0);
      end
      n_checks++;
      if (out1 !== 15'd0) begin
        n_errors++;
        $display("FAIL reset_dut1: got %h expected %h", out1, 15'd0);
      end
    end
  endtask

  task automatic test_clean();
    dur = '{5, 2, 5, 2};
    do_reset();
    step(1'b0, 1'b0, pat[0]);
    n_checks++;
    if ({phase0, synced0} !== {2'd0, 1'b1}) begin
      n_errors++;
      $display("FAIL clean_sync: got %h expected %h", {phase0, synced0}, {2'd0, 1'b1});
    end
    for (int c = 0; c < 5; c++) begin
      for (int p = 0; p < 4; p++) begin
        run_phase(p, dur[p], 1, 6);
        n_checks++;
        if (out0 !== model_vec()) begin
          n_errors++;
          $display("FAIL clean_track: got %h expected %h", out0, model_vec());
        end
      end
    end
    step(1'b0, 1'b0, pat[0]);
    n_checks++;
    if ({err0, cycles0} !== {1'b0, 8'd5}) begin
      n_errors++;
      $display("FAIL clean_cycles: got %h expected %h", {err0, cycles0}, {1'b0, 8'd5});
    end
    n_checks++;
    if (out0 !== model_vec()) begin
      n_errors++;
      $display("FAIL clean_end: got %h expected %h", out0, model_vec());
    end
  endtask

  task automatic test_early_exit();
    dur = '{5, 2, 5, 2};
    do_reset();
    run_phase(0, 5, 1, 4);
    run_phase(1, 2, 1, 4);
    run_phase(2, 5, 1, 4);
    run_phase(3, 2, 1, 4);
    run_phase(0, 3, 1, 4);
    step(1'b0, 1'b0, pat[1]);
    n_checks++;
    if (err_code0 !== 3'd3) begin
      n_errors++;
      $display("FAIL early_code: got %0d expected %0d", err_code0, 3);
    end
    run_phase(1, 2, 1, 4);
    run_phase(2, 5, 1, 4);
    run_phase(3, 2, 1, 4);
    step(1'b0, 1'b0, pat[0]);
    n_checks++;
    if ({err_code0, cycles0} !== {3'd3, 8'd2}) begin
      n_errors++;
      $display("FAIL early_cycles: got %h expected %h", {err_code0, cycles0}, {3'd3, 8'd2});
    end
    n_checks++;
    if (out0 !== model_vec()) begin
      n_errors++;
      $display("FAIL early_model: got %h expected %h", out0, model_vec());
    end
  endtask

  task automatic test_illegal();
    logic [5:0] both_green;
    dur = '{5, 2, 5, 2};
    both_green = 6'b100100;
    do_reset();
    run_phase(0, 3, 1, 4);
    step(1'b0, 1'b0, both_green);
    n_checks++;
    if ({err0, err_code0, phase0} !== {1'b1, 3'd1, 2'd0}) begin
      n_errors++;
      $display("FAIL illegal_code: got %h expected %h", {err0, err_code0, phase0}, {1'b1, 3'd1, 2'd0});
    end
    step(1'b0, 1'b0, pat[0]);
    step(1'b0, 1'b0, pat[2]);
    n_checks++;
    if ({err_code0, phase0} !== {3'd1, 2'd2}) begin
      n_errors++;
      $display("FAIL illegal_sticky: got %h expected %h", {err_code0, phase0}, {3'd1, 2'd2});
    end
    n_checks++;
    if (out0 !== model_vec()) begin
      n_errors++;
      $display("FAIL illegal_model: got %h expected %h", out0, model_vec());
    end
  endtask

  task automatic test_unsync();
    dur = '{5, 2, 5, 2};
    do_reset();
    run_phase(0, 2, 1, 3);
    run_phase(1, 1, 1, 3);
    step(1'b0, 1'b0, pat[1]);
    n_checks++;
    if (err0 !== 1'b0) begin
      n_errors++;
      $display("FAIL unsync_pre: got %0d expected %0d", err0, 0);
    end
    step(1'b0, 1'b0, pat[2]);
    n_checks++;
    if (err_code0 !== 3'd4) begin
      n_errors++;
      $display("FAIL unsync_code: got %0d expected %0d", err_code0, 4);
    end
    n_checks++;
    if (out0 !== model_vec()) begin
      n_errors++;
      $display("FAIL unsync_model: got %h expected %h", out0, model_vec());
    end
  endtask

  task automatic test_overstay();
    dur = '{5, 2, 5, 2};
    do_reset();
    run_phase(0, 1, 1, 4);
    run_phase(1, 2, 1, 4);
    run_phase(2, 5, 1, 4);
    run_phase(3, 2, 1, 4);
    n_checks++;
    if (err0 !== 1'b0) begin
      n_errors++;
      $display("FAIL overstay_pre: got %0d expected %0d", err0, 0);
    end
    step(1'b0, 1'b0, pat[3]);
    n_checks++;
    if (err_code0 !== 3'd3) begin
      n_errors++;
      $display("FAIL overstay_code: got %0d expected %0d", err_code0, 3);
    end
    step(1'b1, 1'b0, pat[3]);
    n_checks++;
    if (out0 !== 15'd0) begin
      n_errors++;
      $display("FAIL overstay_reset: got %h expected %h", out0, 15'd0);
    end
    step(1'b0, 1'b0, pat[1]);
    n_checks++;
    if (out0 !== {2'd1, 1'b1, 1'b0, 3'd0, 8'd0}) begin
      n_errors++;
      $display("FAIL overstay_resync: got %h expected %h", out0, {2'd1, 1'b1, 1'b0, 3'd0, 8'd0});
    end
  endtask

  task automatic test_saturation();
    dur = '{1, 1, 1, 1};
    do_reset();
    for (int c = 0; c < 300; c++) begin
      for (int p = 0; p < 4; p++) run_phase(p, 1, 2, 2);
      if (c == 100 || c == 254) begin
        n_checks++;
        if (out1 !== model_vec()) begin
          n_errors++;
          $display("FAIL sat_mid: got %h expected %h", out1, model_vec());
        end
      end
    end
    step(1'b0, 1'b0, pat[0]);
    n_checks++;
    if ({err1, cycles1} !== {1'b0, 8'd255}) begin
      n_errors++;
      $display("FAIL sat_hold: got %h expected %h", {err1, cycles1}, {1'b0, 8'd255});
    end
    n_checks++;
    if (out1 !== model_vec()) begin
      n_errors++;
      $display("FAIL sat_model: got %h expected %h", out1, model_vec());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clean();
    test_early_exit();
    test_illegal();
    test_unsync();
    test_overstay();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
